// File: rtl/counter_table.sv
// counter_table: branch-predictor pattern history table.
// 2^BPRED_WIDTH two-bit saturating counters, read combinationally and trained
// with the resolved branch outcome. Build option: define COUNTER_TABLE_BYPASS_EN
// to forward the post-update counter MSB to o_Prediction during an update cycle.
module counter_table #(
   parameter int BPRED_WIDTH = 9
) (
   input  logic                   i_Clk,
   input  logic                   i_Reset,
   input  logic                   i_Enable,
   input  logic [BPRED_WIDTH-1:0] i_Index,
   input  logic                   i_ALU_Branch_Outcome,
   output logic                   o_Prediction
);

   localparam int DEPTH = 1 << BPRED_WIDTH;

   // Flat packed storage: entry n lives in bits [2n+1:2n], which lets the
   // whole table be re-initialised in one cycle without a loop.
   logic [2*DEPTH-1:0]    r_Table;
   logic [BPRED_WIDTH:0]  w_Base;
   logic [1:0]            w_Cur;
   logic [1:0]            w_Next;

   // Two-bit saturating step: counts toward 11 on taken, toward 00 otherwise.
   function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
      if (taken) begin
         return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
      end
      return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
   endfunction

   assign w_Base = {i_Index, 1'b0};
   assign w_Cur  = r_Table[w_Base +: 2];
   assign w_Next = sat_step(w_Cur, i_ALU_Branch_Outcome);

`ifdef COUNTER_TABLE_BYPASS_EN
   // During an accepted update the prediction reflects the post-update counter.
   assign o_Prediction = (i_Reset && i_Enable) ? w_Next[1] : w_Cur[1];
`else
   // Read-before-write: the prediction always reflects the stored counter.
   assign o_Prediction = w_Cur[1];
`endif

   // Reset loads every entry with weakly-taken; otherwise train the indexed entry.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset) begin
         r_Table <= {DEPTH{2'b10}};
      end else if (i_Enable) begin
         r_Table[w_Base +: 2] <= w_Next;
      end
   end

endmodule

// File: tb/tb_counter_table.sv
// tb_counter_table: directed table of training vectors plus randomized traffic
// against an array-of-integers model of the pattern history table.
module tb_counter_table;

   localparam int W     = 9;
   localparam int DEPTH = 1 << W;
`ifdef COUNTER_TABLE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         i_Reset = 1'b0;
   logic         i_Enable = 1'b0;
   logic [W-1:0] i_Index = '0;
   logic         i_Outcome = 1'b0;
   logic         o_Prediction;

   int checks = 0;
   int errors = 0;

   // Model: each entry holds its confidence level 0..3 (3 = strongly taken).
   int mdl [DEPTH];

   typedef struct {
      logic         rst_n;
      logic         en;
      logic [W-1:0] idx;
      logic         taken;
      logic         exp_post;
   } vec_t;

   vec_t vecs [20];

   counter_table #(.BPRED_WIDTH(W)) dut (
      .i_Clk               (clk),
      .i_Reset             (i_Reset),
      .i_Enable            (i_Enable),
      .i_Index             (i_Index),
      .i_ALU_Branch_Outcome(i_Outcome),
      .o_Prediction        (o_Prediction)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_next(input int lvl, input logic taken);
      if (taken) return (lvl < 3) ? lvl + 1 : 3;
      return (lvl > 0) ? lvl - 1 : 0;
   endfunction

   function automatic logic model_pred(input logic rst_n, input logic en,
                                       input logic [W-1:0] idx, input logic taken);
      if (BYP && rst_n && en) return (model_next(mdl[idx], taken) >= 2);
      return (mdl[idx] >= 2);
   endfunction

   task automatic model_edge(input logic rst_n, input logic en,
                             input logic [W-1:0] idx, input logic taken);
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mdl[i] = 2;
      end else if (en) begin
         mdl[idx] = model_next(mdl[idx], taken);
      end
   endtask

   // One clocked operation: drive, check the same-cycle prediction, take the edge.
   task automatic step(input logic rst_n, input logic en,
                       input logic [W-1:0] idx, input logic taken);
      @(negedge clk);
      i_Reset = rst_n; i_Enable = en; i_Index = idx; i_Outcome = taken;
      #1;
      check("pre_edge_pred", o_Prediction, model_pred(rst_n, en, idx, taken));
      @(posedge clk);
      model_edge(rst_n, en, idx, taken);
      #1;
      i_Reset = 1'b1; i_Enable = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [W-1:0] idx, input logic exp);
      i_Index = idx;
      #1;
      check(name, o_Prediction, exp);
   endtask

   initial begin
      // {rst_n, en, idx, taken, prediction read back after the edge}
      vecs[0]  = '{1'b1, 1'b0, 9'd0,   1'b0, 1'b1};
      vecs[1]  = '{1'b1, 1'b0, 9'd255, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 9'd511, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 9'd0,   1'b0, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 9'd0,   1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 9'd0,   1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 9'd0,   1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 9'd0,   1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 9'd0,   1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 9'd0,   1'b1, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 9'd0,   1'b1, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 9'd0,   1'b1, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 9'd0,   1'b0, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 9'd5,   1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 9'd5,   1'b0, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 9'd6,   1'b1, 1'b1};
      vecs[16] = '{1'b1, 1'b0, 9'd5,   1'b1, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 9'd5,   1'b0, 1'b1};
      vecs[18] = '{1'b1, 1'b0, 9'd5,   1'b0, 1'b1};
      vecs[19] = '{1'b1, 1'b0, 9'd0,   1'b0, 1'b1};

      // Hold reset low for two edges; the model starts known after that.
      i_Reset = 1'b0;
      repeat (2) @(posedge clk);
      model_edge(1'b0, 1'b0, '0, 1'b0);
      #1;
      i_Reset = 1'b1;
      read_chk("reset_idx0", 9'd0, 1'b1);
      read_chk("reset_idx6", 9'd6, 1'b1);

      // Directed table.
      for (int v = 0; v < 20; v++) begin
         step(vecs[v].rst_n, vecs[v].en, vecs[v].idx, vecs[v].taken);
         read_chk($sformatf("vec%0d_post", v), vecs[v].idx, vecs[v].exp_post);
      end

      // Same-cycle visibility of an update: entry 7 sits at weakly taken.
      @(negedge clk);
      i_Reset = 1'b1; i_Enable = 1'b1; i_Index = 9'd7; i_Outcome = 1'b0;
      #1;
      check("update_cycle_pred", o_Prediction, BYP ? 1'b0 : 1'b1);
      @(posedge clk);
      model_edge(1'b1, 1'b1, 9'd7, 1'b0);
      #1;
      i_Enable = 1'b0;
      read_chk("after_update_idx7", 9'd7, 1'b0);

      // Randomized traffic, biased toward a few indices so entries saturate.
      for (int n = 0; n < 600; n++) begin
         logic         r_rst;
         logic [W-1:0] r_idx;
         logic [W-1:0] r_rd;
         r_rst = ($urandom_range(0, 63) != 0);
         r_idx = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, DEPTH - 1))
                                             : W'($urandom_range(0, 7));
         step(r_rst, 1'($urandom_range(0, 1)), r_idx, 1'($urandom_range(0, 1)));
         r_rd = ($urandom_range(0, 1) == 0) ? r_idx : W'($urandom_range(0, 7));
         read_chk("rand_post", r_rd, (mdl[r_rd] >= 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
